// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM state type
// and the request fault classifier used at accept time.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } lsu_state_e;

  // Illegal funct3 or misaligned address; such requests never touch memory.
  function automatic logic lsu_fault(input logic       is_store,
                                     input logic [2:0] funct3,
                                     input logic [1:0] lane);
    logic illegal;
    logic misaligned;
    illegal    = is_store ? (funct3 > F3_W) : ((funct3 == 3'd3) || (funct3 > F3_HU));
    misaligned = 1'b0;
    case (funct3)
      F3_H, F3_HU: misaligned = lane[0];
      F3_W:        misaligned = |lane;
      default:     misaligned = 1'b0;
    endcase
    return illegal || misaligned;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: extracts and extends load data from a memory word,
// and merges sub-word store data into the word read for read-modify-write.
module load_store_unit_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_rword,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_store_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_byte       = i_rword[{i_lane, 3'b000} +: 8];
    w_half       = i_lane[1] ? i_rword[31:16] : i_rword[15:0];
    o_load_data  = i_rword;
    o_store_word = i_wdata;
    case (i_funct3)
      F3_B: begin
        o_load_data  = {{24{w_byte[7]}}, w_byte};
        o_store_word = i_rword;
        o_store_word[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
      end
      F3_H: begin
        o_load_data  = {{16{w_half[15]}}, w_half};
        o_store_word = i_lane[1] ? {i_wdata[15:0], i_rword[15:0]}
                                 : {i_rword[31:16], i_wdata[15:0]};
      end
      F3_BU:   o_load_data = {24'd0, w_byte};
      F3_HU:   o_load_data = {16'd0, w_half};
      default: o_load_data = i_rword;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request in flight, sub-word stores by read-modify-write.
// Define LSU_PERF_CNT_EN to build the load/store/fault performance counters.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data,
  output logic [CNT_W-1:0]  load_count,
  output logic [CNT_W-1:0]  store_count,
  output logic [CNT_W-1:0]  fault_count
);

  lsu_state_e  r_state;
  logic        r_is_store;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;
  logic [31:0] r_wdata;

  logic        w_fault;
  logic [31:0] w_load_data;
  logic [31:0] w_store_word;

  assign w_fault = lsu_fault(req_is_store, req_funct3, req_addr[1:0]);

  load_store_unit_align u_align (
    .i_funct3     (r_funct3),
    .i_lane       (r_lane),
    .i_rword      (mem_read_data),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_data),
    .o_store_word (w_store_word)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_is_store     <= 1'b0;
      r_funct3       <= 3'd0;
      r_lane         <= 2'd0;
      r_wdata        <= 32'd0;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_rdata     <= 32'd0;
      resp_fault     <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_is_store <= req_is_store;
            r_funct3   <= req_funct3;
            r_lane     <= req_addr[1:0];
            r_wdata    <= req_wdata;
            req_ready  <= 1'b0;
            if (w_fault) begin
              r_state    <= S_RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_rdata <= 32'd0;
            end else begin
              mem_address <= {req_addr[ADDR_W-1:2], 2'b00};
              // Only a full-word store can skip the read; SB/SH need the old word.
              if (req_is_store && (req_funct3 == F3_W)) begin
                r_state        <= S_WRITE;
                mem_write      <= 1'b1;
                mem_write_data <= req_wdata;
              end else begin
                r_state  <= S_READ;
                mem_read <= 1'b1;
              end
            end
          end
        end
        S_READ: begin
          mem_read <= 1'b0;
          if (r_is_store) begin
            r_state        <= S_WRITE;
            mem_write      <= 1'b1;
            mem_write_data <= w_store_word;
          end else begin
            r_state    <= S_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= w_load_data;
          end
        end
        S_WRITE: begin
          mem_write  <= 1'b0;
          r_state    <= S_RESP;
          resp_valid <= 1'b1;
          resp_rdata <= 32'd0;
        end
        default: begin
          r_state    <= S_IDLE;
          resp_valid <= 1'b0;
          resp_fault <= 1'b0;
          resp_rdata <= 32'd0;
          req_ready  <= 1'b1;
        end
      endcase
    end
  end

`ifdef LSU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      load_count  <= '0;
      store_count <= '0;
      fault_count <= '0;
    end else if (r_state == S_RESP) begin
      if (resp_fault)      fault_count <= fault_count + CNT_W'(1);
      else if (r_is_store) store_count <= store_count + CNT_W'(1);
      else                 load_count  <= load_count + CNT_W'(1);
    end
  end
`else
  assign load_count  = '0;
  assign store_count = '0;
  assign fault_count = '0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: table of requests against a small word
// memory model, plus hand-written reset-abort and back-to-back sequences.
module tb_load_store_unit;

  localparam int NV = 23;

  typedef struct {
    logic        is_store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_fault;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_maddr;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic [31:0] load_count;
  logic [31:0] store_count;
  logic [31:0] fault_count;

  logic [31:0] mem [0:63];
  int          n_tests = 0;
  int          n_fail = 0;
  int          n_rd = 0;
  int          n_wr = 0;
  int          n_resp = 0;
  logic [31:0] last_addr = 32'd0;
  vec_t        vecs [NV];

  load_store_unit #(.ADDR_W(32), .CNT_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_is_store   (req_is_store),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_fault     (resp_fault),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .load_count     (load_count),
    .store_count    (store_count),
    .fault_count    (fault_count)
  );

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_address[7:2]];

  always @(posedge clk) begin
    if (mem_write) mem[mem_address[7:2]] <= mem_write_data;
  end

  always @(negedge clk) begin
    if (mem_read) begin
      n_rd      = n_rd + 1;
      last_addr = mem_address;
    end
    if (mem_write) begin
      n_wr      = n_wr + 1;
      last_addr = mem_address;
    end
    if (resp_valid) n_resp = n_resp + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic flt, input logic [31:0] rd,
                              input int lat, input int nr, input int nw, input logic [31:0] ma);
    vec_t v;
    v.is_store = st;  v.f3 = f3;          v.addr = a;      v.wdata = wd;
    v.exp_fault = flt; v.exp_rdata = rd;  v.exp_lat = lat;
    v.exp_rd = nr;    v.exp_wr = nw;      v.exp_maddr = ma;
    return v;
  endfunction

  task automatic wait_ready(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) check({name, " ready timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    wait_ready(tag);
    req_valid    = 1'b1;
    req_is_store = v.is_store;
    req_funct3   = v.f3;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    n_rd = 0;
    n_wr = 0;
    @(posedge clk);
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = c;
        break;
      end
    end
    req_valid = 1'b0;
    check({tag, " latency"}, lat, v.exp_lat);
    check({tag, " fault"}, {31'd0, resp_fault}, {31'd0, v.exp_fault});
    check({tag, " rdata"}, resp_rdata, v.exp_rdata);
    check({tag, " reads"}, n_rd, v.exp_rd);
    check({tag, " writes"}, n_wr, v.exp_wr);
    if (v.exp_rd + v.exp_wr > 0) check({tag, " mem_address"}, last_addr, v.exp_maddr);
  endtask

  initial begin
    int exp_loads;
    int exp_stores;
    int exp_faults;
    int resp1;
    int resp2;
    logic rdy2;
    logic rdy3;
    logic [31:0] rdata2;

    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[16] = 32'h8899AABB;

    //          st    f3    addr    wdata          flt   rdata          lat rd wr maddr
    vecs[0]  = mk(1'b0, 3'd0, 32'h41, 32'h0,         1'b0, 32'hFFFFFFAA, 2, 1, 0, 32'h40);
    vecs[1]  = mk(1'b0, 3'd5, 32'h42, 32'h0,         1'b0, 32'h00008899, 2, 1, 0, 32'h40);
    vecs[2]  = mk(1'b0, 3'd2, 32'h40, 32'h0,         1'b0, 32'h8899AABB, 2, 1, 0, 32'h40);
    vecs[3]  = mk(1'b0, 3'd4, 32'h43, 32'h0,         1'b0, 32'h00000088, 2, 1, 0, 32'h40);
    vecs[4]  = mk(1'b0, 3'd1, 32'h40, 32'h0,         1'b0, 32'hFFFFAABB, 2, 1, 0, 32'h40);
    vecs[5]  = mk(1'b1, 3'd0, 32'h43, 32'h12,        1'b0, 32'h0,        3, 1, 1, 32'h40);
    vecs[6]  = mk(1'b0, 3'd2, 32'h40, 32'h0,         1'b0, 32'h1299AABB, 2, 1, 0, 32'h40);
    vecs[7]  = mk(1'b1, 3'd2, 32'h80, 32'hDEADBEEF,  1'b0, 32'h0,        2, 0, 1, 32'h80);
    vecs[8]  = mk(1'b0, 3'd2, 32'h80, 32'h0,         1'b0, 32'hDEADBEEF, 2, 1, 0, 32'h80);
    vecs[9]  = mk(1'b1, 3'd1, 32'h82, 32'h5555CAFE,  1'b0, 32'h0,        3, 1, 1, 32'h80);
    vecs[10] = mk(1'b0, 3'd2, 32'h80, 32'h0,         1'b0, 32'hCAFEBEEF, 2, 1, 0, 32'h80);
    vecs[11] = mk(1'b0, 3'd1, 32'h82, 32'h0,         1'b0, 32'hFFFFCAFE, 2, 1, 0, 32'h80);
    vecs[12] = mk(1'b1, 3'd0, 32'h44, 32'hFFFFFF7F,  1'b0, 32'h0,        3, 1, 1, 32'h44);
    vecs[13] = mk(1'b0, 3'd0, 32'h44, 32'h0,         1'b0, 32'h0000007F, 2, 1, 0, 32'h44);
    vecs[14] = mk(1'b0, 3'd2, 32'h42, 32'h0,         1'b1, 32'h0,        1, 0, 0, 32'h0);
    vecs[15] = mk(1'b1, 3'd1, 32'h45, 32'h1234,      1'b1, 32'h0,        1, 0, 0, 32'h0);
    vecs[16] = mk(1'b0, 3'd1, 32'h41, 32'h0,         1'b1, 32'h0,        1, 0, 0, 32'h0);
    vecs[17] = mk(1'b0, 3'd3, 32'h40, 32'h0,         1'b1, 32'h0,        1, 0, 0, 32'h0);
    vecs[18] = mk(1'b1, 3'd4, 32'h40, 32'h77,        1'b1, 32'h0,        1, 0, 0, 32'h0);
    vecs[19] = mk(1'b0, 3'd5, 32'h43, 32'h0,         1'b1, 32'h0,        1, 0, 0, 32'h0);
    vecs[20] = mk(1'b1, 3'd2, 32'h81, 32'hFFFFFFFF,  1'b1, 32'h0,        1, 0, 0, 32'h0);
    vecs[21] = mk(1'b0, 3'd7, 32'h40, 32'h0,         1'b1, 32'h0,        1, 0, 0, 32'h0);
    vecs[22] = mk(1'b0, 3'd2, 32'h40, 32'h0,         1'b0, 32'h1299AABB, 2, 1, 0, 32'h40);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset req_ready", {31'd0, req_ready}, 32'd1);
    check("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    check("reset resp_rdata", resp_rdata, 32'd0);
    check("reset resp_fault", {31'd0, resp_fault}, 32'd0);
    check("reset mem_read", {31'd0, mem_read}, 32'd0);
    check("reset mem_write", {31'd0, mem_write}, 32'd0);
    check("reset mem_address", mem_address, 32'd0);
    check("reset mem_write_data", mem_write_data, 32'd0);
    check("reset load_count", load_count, 32'd0);
    reset = 1'b0;

    exp_loads = 0;
    exp_stores = 0;
    exp_faults = 0;
    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
      if (vecs[i].exp_fault)     exp_faults++;
      else if (vecs[i].is_store) exp_stores++;
      else                       exp_loads++;
    end

    @(negedge clk);
`ifdef LSU_PERF_CNT_EN
    check("load_count", load_count, exp_loads);
    check("store_count", store_count, exp_stores);
    check("fault_count", fault_count, exp_faults);
`else
    check("load_count tied", load_count, 32'd0);
    check("store_count tied", store_count, 32'd0);
    check("fault_count tied", fault_count, 32'd0);
`endif

    // Back-to-back: LW held valid; responses at cycles 2 and 5, ready returns at cycle 3.
    wait_ready("b2b");
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h40;
    resp1 = 0; resp2 = 0; rdy2 = 1'b1; rdy3 = 1'b0; rdata2 = 32'd0;
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 2) rdy2 = req_ready;
      if (c == 3) rdy3 = req_ready;
      if (resp_valid) begin
        if (resp1 == 0) resp1 = c;
        else if (resp2 == 0) begin
          resp2  = c;
          rdata2 = resp_rdata;
        end
      end
    end
    req_valid = 1'b0;
    check("b2b first resp cycle", resp1, 32'd2);
    check("b2b second resp cycle", resp2, 32'd5);
    check("b2b ready during resp", {31'd0, rdy2}, 32'd0);
    check("b2b ready after resp", {31'd0, rdy3}, 32'd1);
    check("b2b second rdata", rdata2, 32'h1299AABB);

    // Reset while an SB sits in READ: the write and response must both vanish.
    wait_ready("rst");
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'd0;
    req_addr = 32'h40; req_wdata = 32'h33;
    @(posedge clk);
    @(negedge clk);
    check("rst in READ strobe", {31'd0, mem_read}, 32'd1);
    req_valid = 1'b0;
    reset = 1'b1;
    n_wr = 0;
    n_resp = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst req_ready", {31'd0, req_ready}, 32'd1);
    check("rst mem_read", {31'd0, mem_read}, 32'd0);
    check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst load_count", load_count, 32'd0);
    check("rst store_count", store_count, 32'd0);
    check("rst fault_count", fault_count, 32'd0);
    repeat (3) @(negedge clk);
    check("rst no write", n_wr, 32'd0);
    check("rst no resp", n_resp, 32'd0);
    run_vec(vecs[22], "rst mem unchanged");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
